// File: rtl/systolic_tile_sequencer.sv
// Sequences one output tile of the systolic array: clear, feed K operand rows,
// flush the array skew, then optionally commit results to the output buffer.
module systolic_tile_sequencer #(
  parameter int unsigned ARR_SIZE = 4,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned KLEN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [KLEN_W-1:0] cmd_k_len,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [3:0]        cmd_op_base,
  input  logic              cmd_store,
  input  logic              stall,
  input  logic              abort,
  output logic [1:0]        state_signal,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              acc_reset,
  output logic              acc_store,
  output logic [3:0]        acc_op_addr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OP_W      = 4;
  localparam int unsigned FLUSH_LEN = 2 * ARR_SIZE - 2;
  localparam int unsigned FCNT_W    = $clog2(2 * ARR_SIZE) + 1;
  localparam int unsigned J_W       = $clog2(ARR_SIZE) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_STORE,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic [KLEN_W-1:0]   k, k_n;
  logic [FCNT_W-1:0]   fcnt, fcnt_n;
  logic [J_W-1:0]      j, j_n;
  logic                accept;

  logic [KLEN_W-1:0]   k_len_q;
  logic [ADDR_W-1:0]   base_q;
  logic [OP_W-1:0]     op_base_q;
  logic                store_q;

  logic                cmd_ready_n;
  logic [1:0]          state_signal_n;
  logic                buf_rd_en_n;
  logic [ADDR_W-1:0]   buf_rd_addr_n;
  logic                acc_reset_n;
  logic                acc_store_n;
  logic [OP_W-1:0]     acc_op_addr_n;
  logic                busy_n;
  logic                done_n;

  // Next-state, counters and the next value of every registered output.
  // FEED/STORE progress is judged on the beat just issued (its strobe flop).
  always_comb begin
    state_n = state;
    k_n     = k;
    fcnt_n  = fcnt;
    j_n     = j;
    accept  = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_n = (cmd_k_len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_n = S_FEED;
        k_n     = '0;
      end
      S_FEED: begin
        if (buf_rd_en) begin
          if (k == k_len_q - KLEN_W'(1)) begin
            state_n = S_FLUSH;
            fcnt_n  = '0;
          end else begin
            k_n = k + KLEN_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (fcnt == FCNT_W'(FLUSH_LEN - 1)) begin
          state_n = store_q ? S_STORE : S_DONE;
          j_n     = '0;
        end else begin
          fcnt_n = fcnt + FCNT_W'(1);
        end
      end
      S_STORE: begin
        if (acc_store) begin
          if (j == J_W'(ARR_SIZE - 1)) begin
            state_n = S_DONE;
          end else begin
            j_n = j + J_W'(1);
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
    end

    cmd_ready_n    = (state_n == S_IDLE);
    busy_n         = (state_n != S_IDLE);
    acc_reset_n    = (state_n == S_CLEAR);
    done_n         = (state_n == S_DONE);
    buf_rd_en_n    = 1'b0;
    buf_rd_addr_n  = '0;
    acc_store_n    = 1'b0;
    acc_op_addr_n  = '0;
    state_signal_n = 2'b00;

    case (state_n)
      S_CLEAR: state_signal_n = 2'b01;
      S_FEED: begin
        state_signal_n = 2'b10;
        buf_rd_en_n    = !stall;
        buf_rd_addr_n  = base_q + ADDR_W'(k_n);
      end
      S_FLUSH: state_signal_n = 2'b10;
      S_STORE: begin
        state_signal_n = 2'b11;
        acc_store_n    = !stall;
        acc_op_addr_n  = op_base_q + OP_W'(j_n);
      end
      S_DONE:  state_signal_n = 2'b11;
      default: state_signal_n = 2'b00;
    endcase
  end

  // State, counters and the command latched at the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      k         <= '0;
      fcnt      <= '0;
      j         <= '0;
      k_len_q   <= '0;
      base_q    <= '0;
      op_base_q <= '0;
      store_q   <= 1'b0;
    end else begin
      state <= state_n;
      k     <= k_n;
      fcnt  <= fcnt_n;
      j     <= j_n;
      if (accept) begin
        k_len_q   <= cmd_k_len;
        base_q    <= cmd_base_addr;
        op_base_q <= cmd_op_base;
        store_q   <= cmd_store;
      end
    end
  end

  // Output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready    <= 1'b1;
      state_signal <= 2'b00;
      buf_rd_en    <= 1'b0;
      buf_rd_addr  <= '0;
      acc_reset    <= 1'b0;
      acc_store    <= 1'b0;
      acc_op_addr  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      cmd_ready    <= cmd_ready_n;
      state_signal <= state_signal_n;
      buf_rd_en    <= buf_rd_en_n;
      buf_rd_addr  <= buf_rd_addr_n;
      acc_reset    <= acc_reset_n;
      acc_store    <= acc_store_n;
      acc_op_addr  <= acc_op_addr_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: per-cycle outputs compared against a
// schedule expanded from each tile command (phases, beats, stalls, aborts).
module tb_systolic_tile_sequencer;

  localparam int N     = 4;
  localparam int FLUSH = 2 * N - 2;
  localparam int MAXC  = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_k_len;
  logic [6:0] cmd_base_addr;
  logic [3:0] cmd_op_base;
  logic       cmd_store;
  logic       stall;
  logic       abort;
  logic [1:0] state_signal;
  logic       buf_rd_en;
  logic [6:0] buf_rd_addr;
  logic       acc_reset;
  logic       acc_store;
  logic [3:0] acc_op_addr;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  systolic_tile_sequencer #(.ARR_SIZE(N), .ADDR_W(7), .KLEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k_len(cmd_k_len),
    .cmd_base_addr(cmd_base_addr), .cmd_op_base(cmd_op_base), .cmd_store(cmd_store),
    .stall(stall), .abort(abort), .state_signal(state_signal),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .acc_reset(acc_reset),
    .acc_store(acc_store), .acc_op_addr(acc_op_addr), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic [1:0] sig;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic       acc_reset;
    logic       acc_store;
    logic [3:0] op_addr;
    logic       done;
  } obs_t;

  obs_t       exp_a [MAXC];
  obs_t       obs_a [MAXC];
  bit         valid_a [MAXC];
  bit         stall_a [MAXC];
  bit         abort_a [MAXC];
  bit         store_a [MAXC];
  int         k_a [MAXC];
  logic [6:0] base_a [MAXC];
  logic [3:0] op_a [MAXC];

  int errors = 0;
  int checks = 0;

  function automatic obs_t idle_e();
    obs_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t e;
    e.ready     = cmd_ready;
    e.busy      = busy;
    e.sig       = state_signal;
    e.rd_en     = buf_rd_en;
    e.rd_addr   = buf_rd_addr;
    e.acc_reset = acc_reset;
    e.acc_store = acc_store;
    e.op_addr   = acc_op_addr;
    e.done      = done;
    return e;
  endfunction

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      valid_a[c] = 1'b0; stall_a[c] = 1'b0; abort_a[c] = 1'b0; store_a[c] = 1'b0;
      k_a[c] = 0; base_a[c] = '0; op_a[c] = '0;
      exp_a[c] = idle_e(); obs_a[c] = '0;
    end
  endtask

  // Reference: expand one command into its cycle-by-cycle phase schedule.
  // Cycle c reflects stall/abort/cmd presented at the edge that opens it.
  task automatic model_tile(input int start, input int k, input logic [6:0] base,
                            input logic [3:0] op, input bit st, input int ab,
                            output int nxt);
    int c;
    int b;
    obs_t e;
    valid_a[start] = 1'b1; k_a[start] = k; base_a[start] = base;
    op_a[start] = op; store_a[start] = st;
    c = start;
    if (k > 0) begin
      e = '0; e.busy = 1'b1; e.sig = 2'b01; e.acc_reset = 1'b1;
      exp_a[c] = e; c++;
      b = 0;
      while (b < k && c < MAXC - 40) begin
        e = '0; e.busy = 1'b1; e.sig = 2'b10;
        e.rd_addr = 7'(int'(base) + b);
        e.rd_en = !stall_a[c];
        if (!stall_a[c]) b++;
        exp_a[c] = e; c++;
      end
      for (int i = 0; i < FLUSH; i++) begin
        e = '0; e.busy = 1'b1; e.sig = 2'b10;
        exp_a[c] = e; c++;
      end
      if (st) begin
        b = 0;
        while (b < N && c < MAXC - 20) begin
          e = '0; e.busy = 1'b1; e.sig = 2'b11;
          e.op_addr = 4'(int'(op) + b);
          e.acc_store = !stall_a[c];
          if (!stall_a[c]) b++;
          exp_a[c] = e; c++;
        end
      end
    end
    e = '0; e.busy = 1'b1; e.sig = 2'b11; e.done = 1'b1;
    exp_a[c] = e; c++;
    exp_a[c] = idle_e();
    nxt = c + 1;
    if (ab > start && ab <= c) begin
      for (int i = ab; i <= c; i++) exp_a[i] = idle_e();
      abort_a[ab] = 1'b1;
      nxt = ab + 1;
    end else if (ab == start) begin
      abort_a[ab] = 1'b1;
    end
  endtask

  task automatic drive_schedule(input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      cmd_valid = valid_a[c]; cmd_k_len = 8'(k_a[c]); cmd_base_addr = base_a[c];
      cmd_op_base = op_a[c]; cmd_store = store_a[c];
      stall = stall_a[c]; abort = abort_a[c];
      @(posedge clk);
      #1;
      obs_a[c] = sample();
    end
    cmd_valid = 1'b0; cmd_k_len = '0; cmd_base_addr = '0; cmd_op_base = '0;
    cmd_store = 1'b0; stall = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_k_len = '0; cmd_base_addr = '0; cmd_op_base = '0;
    cmd_store = 1'b0; stall = 1'b0; abort = 1'b0;
    #12;
    checks++;
    if (sample() !== idle_e()) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", sample(), idle_e());
    end
    #9 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sample() !== idle_e()) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", sample(), idle_e());
    end
  endtask

  task automatic test_basic();
    int nxt;
    clear_sched();
    model_tile(1, 4, 7'h10, 4'd0, 1'b1, 0, nxt);
    drive_schedule(nxt - 1);
    for (int c = 1; c < nxt; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL basic cycle %0d: got %h expected %h", c, obs_a[c], exp_a[c]);
      end
    end
    checks++;
    if (obs_a[1].acc_reset !== 1'b1 || obs_a[16].done !== 1'b1 || obs_a[17].ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_timing: acc_reset@1=%b done@16=%b ready@17=%b expected 1 1 1",
               obs_a[1].acc_reset, obs_a[16].done, obs_a[17].ready);
    end
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if (obs_a[c].rd_en !== 1'b1 || obs_a[c].rd_addr !== 7'(14 + c)) begin
        errors++;
        $display("FAIL basic_rd cycle %0d: en=%b addr=%h expected en=1 addr=%h",
                 c, obs_a[c].rd_en, obs_a[c].rd_addr, 7'(14 + c));
      end
    end
    for (int c = 12; c <= 15; c++) begin
      checks++;
      if (obs_a[c].acc_store !== 1'b1 || obs_a[c].op_addr !== 4'(c - 12)) begin
        errors++;
        $display("FAIL basic_store cycle %0d: st=%b addr=%h expected st=1 addr=%h",
                 c, obs_a[c].acc_store, obs_a[c].op_addr, 4'(c - 12));
      end
    end
  endtask

  task automatic test_stall();
    int nxt;
    int beats;
    clear_sched();
    stall_a[3] = 1'b1;
    stall_a[4] = 1'b1;
    model_tile(1, 4, 7'h10, 4'd0, 1'b1, 0, nxt);
    drive_schedule(nxt - 1);
    beats = 0;
    for (int c = 1; c < nxt; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL stall cycle %0d: got %h expected %h", c, obs_a[c], exp_a[c]);
      end
      if (obs_a[c].rd_en === 1'b1) beats++;
    end
    checks++;
    if (beats !== 4 || obs_a[18].done !== 1'b1 || obs_a[4].rd_addr !== 7'h11 || obs_a[4].rd_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_summary: beats=%0d done@18=%b addr@4=%h en@4=%b expected 4 1 11 0",
               beats, obs_a[18].done, obs_a[4].rd_addr, obs_a[4].rd_en);
    end
  endtask

  task automatic test_k_zero();
    int nxt;
    int act;
    clear_sched();
    model_tile(1, 0, 7'h33, 4'd5, 1'b1, 0, nxt);
    drive_schedule(nxt + 1);
    act = 0;
    for (int c = 1; c <= nxt + 1; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL k_zero cycle %0d: got %h expected %h", c, obs_a[c], exp_a[c]);
      end
      if (obs_a[c].rd_en === 1'b1 || obs_a[c].acc_reset === 1'b1 || obs_a[c].acc_store === 1'b1) act++;
    end
    checks++;
    if (obs_a[1].done !== 1'b1 || obs_a[1].ready !== 1'b0 || obs_a[2].ready !== 1'b1 || act !== 0) begin
      errors++;
      $display("FAIL k_zero_summary: done@1=%b ready@1=%b ready@2=%b activity=%0d expected 1 0 1 0",
               obs_a[1].done, obs_a[1].ready, obs_a[2].ready, act);
    end
  endtask

  task automatic test_wrap();
    int nxt;
    clear_sched();
    model_tile(1, 3, 7'h7E, 4'd14, 1'b1, 0, nxt);
    drive_schedule(nxt - 1);
    for (int c = 1; c < nxt; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL wrap cycle %0d: got %h expected %h", c, obs_a[c], exp_a[c]);
      end
    end
    checks++;
    if (obs_a[3].rd_addr !== 7'h7F || obs_a[4].rd_addr !== 7'h00 || obs_a[13].op_addr !== 4'd0 ||
        obs_a[14].op_addr !== 4'd1 || obs_a[15].done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_summary: a3=%h a4=%h op13=%h op14=%h done15=%b expected 7f 00 0 1 1",
               obs_a[3].rd_addr, obs_a[4].rd_addr, obs_a[13].op_addr, obs_a[14].op_addr, obs_a[15].done);
    end
  endtask

  task automatic test_abort();
    int s2;
    int s3;
    int nxt;
    int dones;
    clear_sched();
    model_tile(1, 4, 7'h20, 4'd5, 1'b1, 5, s2);
    model_tile(s2, 2, 7'h40, 4'd9, 1'b1, 0, s3);
    model_tile(s3, 1, 7'h50, 4'd2, 1'b0, s3, nxt);
    drive_schedule(nxt - 1);
    dones = 0;
    for (int c = 1; c < nxt; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL abort cycle %0d: got %h expected %h", c, obs_a[c], exp_a[c]);
      end
      if (c < s2 && obs_a[c].done === 1'b1) dones++;
    end
    checks++;
    if (obs_a[5] !== idle_e() || dones !== 0 || obs_a[s2].acc_reset !== 1'b1) begin
      errors++;
      $display("FAIL abort_summary: c5=%h dones=%0d reset_next=%b expected %h 0 1",
               obs_a[5], dones, obs_a[s2].acc_reset, idle_e());
    end
  endtask

  task automatic test_async_reset();
    int nxt;
    clear_sched();
    model_tile(1, 2, 7'h05, 4'd3, 1'b1, 0, nxt);
    drive_schedule(11);
    for (int c = 1; c <= 11; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL async_pre cycle %0d: got %h expected %h", c, obs_a[c], exp_a[c]);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (sample() !== idle_e()) begin
      errors++;
      $display("FAIL async_reset_drop: got %h expected %h", sample(), idle_e());
    end
    #3 rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      checks++;
      if (sample() !== idle_e()) begin
        errors++;
        $display("FAIL async_after_release: got %h expected %h", sample(), idle_e());
      end
    end
  endtask

  task automatic test_back_to_back();
    int s;
    int nresets;
    int ndones;
    clear_sched();
    for (int c = 1; c < 200; c++) begin
      valid_a[c] = 1'b1;
      k_a[c] = int'($urandom_range(0, 9));
      base_a[c] = 7'($urandom);
      op_a[c] = 4'($urandom);
      store_a[c] = 1'($urandom);
    end
    model_tile(1, 2, 7'h11, 4'd7, 1'b1, 0, s);
    model_tile(s, 0, 7'h22, 4'd1, 1'b1, 0, s);
    model_tile(s, 3, 7'h33, 4'd0, 1'b0, 0, s);
    drive_schedule(s - 1);
    nresets = 0;
    ndones = 0;
    for (int c = 1; c < s; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs_a[c], exp_a[c]);
      end
      if (obs_a[c].acc_reset === 1'b1) nresets++;
      if (obs_a[c].done === 1'b1) ndones++;
    end
    checks++;
    if (nresets !== 2 || ndones !== 3) begin
      errors++;
      $display("FAIL back_to_back_count: clears=%0d dones=%0d expected 2 3", nresets, ndones);
    end
  endtask

  task automatic test_random();
    int s;
    int ab;
    clear_sched();
    for (int c = 1; c < MAXC; c++) stall_a[c] = ($urandom_range(0, 3) == 0);
    s = 1;
    for (int t = 0; t < 20 && s < MAXC - 120; t++) begin
      ab = 0;
      if ($urandom_range(0, 4) == 0) ab = s + int'($urandom_range(0, 12));
      model_tile(s, int'($urandom_range(0, 9)), 7'($urandom), 4'($urandom),
                 1'($urandom), ab, s);
    end
    drive_schedule(s - 1);
    for (int c = 1; c < s; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", c, obs_a[c], exp_a[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_k_zero();
    test_wrap();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_tile_sequencer.md
Name: systolic_tile_sequencer

Overview:
- Sequences one output tile of the ARR_SIZE x ARR_SIZE systolic array.
- Accepts a tile command, then in order:
  - clears the accumulators;
  - streams K operand rows out of the input and weight banked buffers;
  - waits for the array skew to flush;
  - commits the accumulator results to the output buffer.
- Sits between the instruction controller and the banked buffers, MAC array, accumulator and output buffer. It replaces ad-hoc per-instruction pulsing of those blocks.

Parameters:
- ARR_SIZE, 4: array dimension; sets the flush length and the number of store beats.
- ADDR_W, 7: banked-buffer read address width.
- KLEN_W, 8: width of the reduction-length field.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  tile command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_k_len  in  KLEN_W  reduction length K, in rows.
- cmd_base_addr  in  ADDR_W  first buffer row of the tile.
- cmd_op_base  in  4  first output-buffer address for the results.
- cmd_store  in  1  1 = commit results to output buffer; 0 = leave them in the accumulator.
- stall  in  1  freezes FEED and STORE progress (e.g. output buffer busy).
- abort  in  1  synchronous abort to IDLE.
- state_signal  out  2  buffer mode: 00 idle, 01 clear, 10 compute, 11 output.
- buf_rd_en  out  1  read strobe to both banked buffers.
- buf_rd_addr  out  ADDR_W  row address to both banked buffers.
- acc_reset  out  1  accumulator clear pulse.
- acc_store  out  1  accumulator-to-output-buffer commit strobe.
- acc_op_addr  out  4  output-buffer address for the current commit.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state returns to IDLE; all counters clear to 0.
  - All outputs go to 0 except cmd_ready=1.
  - Takes effect mid-tile with no done pulse.
- Every output is registered (driven from state and counter flops); there are no combinational paths from inputs to outputs.
- IDLE:
  - cmd_ready=1, state_signal=00.
  - Command handshake: the command is accepted on the cycle where cmd_valid and cmd_ready are both high. The sequencer latches k_len, base_addr, op_base and store on that cycle.
  - If k_len==0: go to DONE (no buffer or accumulator activity).
  - Otherwise: go to CLEAR.
- CLEAR:
  - Exactly 1 cycle; acc_reset=1, state_signal=01.
  - Next state is FEED with k counter = 0.
- FEED:
  - state_signal=10, buf_rd_en=!stall, buf_rd_addr=base_addr+k.
  - Address addition wraps modulo 2^ADDR_W.
  - k increments only when stall=0.
  - Leaves for FLUSH after the beat with k==k_len-1 is issued unstalled. This gives exactly k_len unstalled read beats.
- FLUSH:
  - state_signal=10, buf_rd_en=0.
  - Counts 2*ARR_SIZE-2 cycles; stall is ignored here.
  - Then goes to STORE if store=1, else to DONE.
- STORE:
  - state_signal=11.
  - acc_store=!stall, acc_op_addr=(op_base+j) mod 16, for j=0..ARR_SIZE-1.
  - j advances only on unstalled beats. After ARR_SIZE beats, go to DONE.
- DONE:
  - Exactly 1 cycle; done=1, state_signal=11, cmd_ready=0.
  - Next state is IDLE.
  - A new command is accepted no earlier than the cycle after DONE.
- cmd_ready is 0 in every state except IDLE. Commands presented while busy are held off, not dropped.
- abort:
  - Sampled in any non-IDLE state.
  - Next cycle: IDLE, all strobes 0, no done pulse.
  - Accumulator contents are left undefined.
  - Abort has priority over stall and over normal state transitions.
  - Abort in IDLE has no effect, and the sequencer still accepts a command in the same cycle.
- Latency, no stall, accept at edge T0:
  - CLEAR during T1; FEED during T2..T(k+1).
  - FLUSH spans 2*ARR_SIZE-2 cycles.
  - STORE spans ARR_SIZE cycles, if store=1.
  - DONE follows.
  - For ARR_SIZE=4, k=4, store=1: done is high in cycle T16.

Test Plan:
1. Reset, then cmd k_len=4, base=0x10, op_base=0, store=1 -> acc_reset in T1; rd_addr 0x10..0x13 in T2..T5; FLUSH T6..T11; acc_store with addr 0..3 in T12..T15; done in T16; busy T1..T16.
2. Same command with stall=1 during T3..T4 -> addresses 0x11 held for 2 extra cycles with rd_en=0, exactly 4 read beats, done in T18.
3. k_len=0 -> no rd_en, no acc_reset, done in T1, cmd_ready back high in T2.
4. base=0x7E, k_len=3; op_base=14, store=1 -> rd_addr 0x7E, 0x7F, 0x00; op addrs 14, 15, 0, 1.
5. abort at the third FEED beat -> IDLE next cycle, no done, cmd_ready=1; a following command completes normally.
6. rst=0 asserted mid-STORE, asynchronous to clk -> outputs drop to 0 immediately, cmd_ready=1 after release; back-to-back commands with cmd_valid held high are each accepted only in IDLE.
